// File: rtl/scmp_pkg.sv
// Shared definitions for the SC/MP memory-side bus controller.
package scmp_pkg;

    // Bus FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_RD_HOLD = 3'd3;
    localparam logic [2:0] ST_WR_DO   = 3'd4;
    localparam logic [2:0] ST_WR_WAIT = 3'd5;

    // Bit positions inside the 4-bit flags word {H,D,I,R}
    localparam int FLAG_H = 3;
    localparam int FLAG_D = 2;
    localparam int FLAG_I = 1;
    localparam int FLAG_R = 0;

    // Value presented to the CPU whenever no read data is being driven
    localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;

    // Bit positions of the strobes inside the synchronized strobe vector
    localparam int STB_ADS = 2;
    localparam int STB_RD  = 1;
    localparam int STB_WR  = 0;

endpackage

// File: rtl/scmp_sync.sv
// Multi-flop synchronizer for asynchronous active-low strobes.
// Flops reset to 1 so a deasserted strobe is seen immediately after reset.
module scmp_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_reg;

    // Shift the raw inputs through STAGES flops; stage 0 is the metastable one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_reg <= '1;
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d};
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/scmp_bus_ctrl.sv
// Memory-side bus controller for the SC/MP CPU: synchronizes the bus strobes,
// latches status flags, runs RAM read/write cycles and stretches reads with hold_n.
module scmp_bus_ctrl
    import scmp_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ads_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [11:0]       cpu_addr,
    input  logic [7:0]        cpu_d_o,
    output logic [7:0]        cpu_d_i,
    output logic              hold_n,
    output logic [3:0]        flags,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              bus_err
);

    logic [2:0]        stb_raw;
    logic [2:0]        stb_s;
    logic [2:0]        stb_prev_reg;
    logic [2:0]        stb_fall;
    logic              rd_s;
    logic              wr_s;
    logic              ads_fall;
    logic              rd_fall;
    logic              wr_fall;
    logic              in_read;
    logic              in_write;
    logic [2:0]        state_reg;
    logic [7:0]        cpu_d_i_reg;
    logic              hold_n_reg;
    logic [3:0]        flags_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_we_reg;
    logic [7:0]        mem_wdata_reg;
    logic              bus_err_reg;
    logic              unused_addr_bits;

    // The RAM is smaller than the CPU space, so upper address bits alias away
    assign unused_addr_bits = ^cpu_addr[11:ADDR_W];

    assign stb_raw = {ads_n, rd_n, wr_n};

    scmp_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (3)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (stb_raw),
        .q     (stb_s)
    );

    // Remember last synchronized strobe levels for fall detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stb_prev_reg <= '1;
        end else begin
            stb_prev_reg <= stb_s;
        end
    end

    assign stb_fall = stb_prev_reg & ~stb_s;
    assign ads_fall = stb_fall[STB_ADS];
    assign rd_fall  = stb_fall[STB_RD];
    assign wr_fall  = stb_fall[STB_WR];
    assign rd_s     = stb_s[STB_RD];
    assign wr_s     = stb_s[STB_WR];

    assign in_read  = (state_reg == ST_RD_REQ) || (state_reg == ST_RD_DATA) ||
                      (state_reg == ST_RD_HOLD);
    assign in_write = (state_reg == ST_WR_DO) || (state_reg == ST_WR_WAIT);

    // Status flags {H,D,I,R} captured on every address strobe, whatever the FSM is doing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_reg <= '0;
        end else if (ads_fall) begin
            flags_reg <= cpu_d_o[7:4];
        end
    end

    // Bus cycle FSM with registered RAM and CPU-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cpu_d_i_reg   <= BUS_IDLE_DATA;
            hold_n_reg    <= 1'b1;
            mem_addr_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_wdata_reg <= '0;
            bus_err_reg   <= 1'b0;
        end else begin
            // Write pulse is the registered image of the WR_DO state
            mem_we_reg <= (state_reg == ST_WR_DO);

            case (state_reg)
                ST_IDLE: begin
                    if (rd_fall) begin
                        // Read has priority; a write strobe low at the same time is a violation
                        state_reg    <= ST_RD_REQ;
                        mem_addr_reg <= cpu_addr[ADDR_W-1:0];
                        hold_n_reg   <= 1'b0;
                        if (!wr_s) begin
                            bus_err_reg <= 1'b1;
                        end
                    end else if (wr_fall && rd_s) begin
                        state_reg     <= ST_WR_DO;
                        mem_addr_reg  <= cpu_addr[ADDR_W-1:0];
                        mem_wdata_reg <= cpu_d_o;
                    end else if (wr_fall) begin
                        bus_err_reg <= 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    if (rd_s) begin
                        state_reg  <= ST_IDLE;
                        hold_n_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rd_s) begin
                        state_reg  <= ST_IDLE;
                        hold_n_reg <= 1'b1;
                    end else begin
                        cpu_d_i_reg <= mem_rdata;
                        hold_n_reg  <= 1'b1;
                        state_reg   <= ST_RD_HOLD;
                    end
                end
                ST_RD_HOLD: begin
                    if (rd_s) begin
                        cpu_d_i_reg <= BUS_IDLE_DATA;
                        state_reg   <= ST_IDLE;
                    end
                end
                ST_WR_DO: begin
                    state_reg <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (wr_s) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    hold_n_reg  <= 1'b1;
                    cpu_d_i_reg <= BUS_IDLE_DATA;
                end
            endcase

            // Opposite strobe falling during an active cycle is flagged but otherwise ignored
            if ((in_read && wr_fall) || (in_write && rd_fall)) begin
                bus_err_reg <= 1'b1;
            end
        end
    end

    assign cpu_d_i   = cpu_d_i_reg;
    assign hold_n    = hold_n_reg;
    assign flags     = flags_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_we    = mem_we_reg;
    assign mem_wdata = mem_wdata_reg;
    assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_scmp_bus_ctrl.sv
// Directed self-checking bench for scmp_bus_ctrl with a small synchronous RAM model.
module tb_scmp_bus_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ads_n;
    logic        rd_n;
    logic        wr_n;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_d_o;
    logic [7:0]  cpu_d_i;
    logic        hold_n;
    logic [3:0]  flags;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        bus_err;

    logic [7:0]  ram [32];
    logic        pre_en;
    logic [4:0]  pre_addr;
    logic [7:0]  pre_data;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  rd_exp_q [$];
    logic [12:0] wr_exp_q [$];

    scmp_bus_ctrl #(
        .ADDR_W      (5),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ads_n     (ads_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .cpu_addr  (cpu_addr),
        .cpu_d_o   (cpu_d_o),
        .cpu_d_i   (cpu_d_i),
        .hold_n    (hold_n),
        .flags     (flags),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, one-cycle read latency, with a bench-side preload port
    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every write pulse must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we !== 1'b0) begin
            if (wr_exp_q.size() == 0) begin
                check("unexpected_mem_we", {31'd0, mem_we}, 32'd0);
            end else begin
                logic [12:0] e;
                e = wr_exp_q.pop_front();
                check("wr_addr_data", {19'd0, mem_addr, mem_wdata}, {19'd0, e});
                $display("write: addr=0x%0h data=0x%0h", mem_addr, mem_wdata);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_d_i"}, {24'd0, cpu_d_i}, 32'hFF);
        check({tag, "_hold_n"}, {31'd0, hold_n}, 32'd1);
        check({tag, "_flags"}, {28'd0, flags}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, {27'd0, mem_addr}, 32'd0);
        check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
        check({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
    endtask

    // Full read cycle: hold_n must fall after E2, rise with data after E4,
    // and cpu_d_i must return to idle three edges after rd_n rises.
    task automatic do_read(input logic [11:0] addr, input logic [7:0] exp);
        int low_k;
        int high_k;
        logic [7:0] e;
        rd_exp_q.push_back(exp);
        cpu_addr = addr;
        rd_n     = 1'b0;
        low_k    = -1;
        high_k   = -1;
        e        = 8'hFF;
        for (int k = 1; k <= 20 && high_k < 0; k++) begin
            @(negedge clk);
            if (hold_n === 1'b0 && low_k < 0) begin
                low_k = k;
                check("rd_mem_addr", {27'd0, mem_addr}, {27'd0, addr[4:0]});
            end
            if (hold_n === 1'b1 && low_k >= 0) high_k = k;
        end
        check("rd_hold_low_edge", low_k, 3);
        check("rd_hold_high_edge", high_k, 5);
        e = rd_exp_q.pop_front();
        check("rd_data", {24'd0, cpu_d_i}, {24'd0, e});
        $display("read: addr=0x%0h data=0x%0h hold_low@%0d hold_high@%0d", addr, cpu_d_i, low_k, high_k);
        rd_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rd_data_held", {24'd0, cpu_d_i}, {24'd0, e});
        @(negedge clk);
        check("rd_release_ff", {24'd0, cpu_d_i}, 32'hFF);
    endtask

    initial begin
        int we_n;
        int we_k;
        int low_cnt;
        int bad_d;
        int err_seen;

        rst_n    = 1'b0;
        ads_n    = 1'b1;
        rd_n     = 1'b1;
        wr_n     = 1'b1;
        cpu_addr = 12'h000;
        cpu_d_o  = 8'h00;
        pre_en   = 1'b1;
        pre_addr = 5'd5;
        pre_data = 8'hA7;
        repeat (3) @(negedge clk);
        pre_en = 1'b0;
        check_reset_values("reset");
        $display("reset: values checked");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Flags latched from the status byte at the address strobe
        cpu_d_o = 8'hA0;
        ads_n   = 1'b0;
        repeat (2) @(negedge clk);
        check("flags_before_e2", {28'd0, flags}, 32'd0);
        @(negedge clk);
        check("flags_at_e2", {28'd0, flags}, 32'hA);
        $display("flags: 0x%0h", flags);
        ads_n   = 1'b1;
        cpu_d_o = 8'h55;
        repeat (3) @(negedge clk);

        // Read with address aliasing (0x025 -> RAM[5])
        do_read(12'h025, 8'hA7);
        repeat (2) @(negedge clk);

        // Write held for 10 clocks must produce exactly one pulse after E3
        cpu_addr = 12'h003;
        cpu_d_o  = 8'h3C;
        wr_n     = 1'b0;
        wr_exp_q.push_back({5'd3, 8'h3C});
        we_n = 0;
        we_k = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                we_n++;
                we_k = k;
            end
        end
        wr_n = 1'b1;
        check("wr_pulse_count", we_n, 1);
        check("wr_pulse_edge", we_k, 4);
        repeat (4) @(negedge clk);

        do_read(12'h003, 8'h3C);
        check("flags_unchanged", {28'd0, flags}, 32'hA);
        check("wr_queue_empty", wr_exp_q.size(), 0);
        repeat (2) @(negedge clk);

        // Aborted read: one-clock rd_n pulse
        cpu_addr = 12'h025;
        rd_n     = 1'b0;
        @(negedge clk);
        rd_n    = 1'b1;
        low_cnt = 0;
        bad_d   = 0;
        err_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (hold_n !== 1'b1) low_cnt++;
            if (cpu_d_i !== 8'hFF) bad_d++;
            if (bus_err !== 1'b0) err_seen++;
        end
        check("abort_hold_pulse_1to2", {31'd0, (low_cnt >= 1 && low_cnt <= 2)}, 32'd1);
        check("abort_cpu_d_i_idle", bad_d, 0);
        check("abort_no_bus_err", err_seen, 0);
        $display("abort: hold_low_cycles=%0d", low_cnt);

        // Simultaneous read and write strobes: read wins, no write, sticky error
        wr_n = 1'b0;
        do_read(12'h005, 8'hA7);
        check("violation_bus_err", {31'd0, bus_err}, 32'd1);
        wr_n = 1'b1;
        repeat (5) @(negedge clk);
        check("violation_bus_err_sticky", {31'd0, bus_err}, 32'd1);
        check("violation_no_write", wr_exp_q.size(), 0);
        $display("violation: bus_err=%0b", bus_err);

        // Reset while the FSM sits in RD_DATA
        cpu_addr = 12'h003;
        rd_n     = 1'b0;
        repeat (4) @(negedge clk);
        check("midread_hold_low", {31'd0, hold_n}, 32'd0);
        rst_n = 1'b0;
        rd_n  = 1'b1;
        @(negedge clk);
        check_reset_values("midread_reset");
        $display("midread reset: values checked");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_read(12'h025, 8'hA7);
        check("rd_queue_empty", rd_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
